// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment display scanner.
// Scans DIGITS digits in time slots of TICK_DIV clocks, PWM-dims the lit digit,
// and double-buffers the displayed data so a frame never shows mixed content.

// Hex nibble to active-low segments, g..a = seg_n[6:0].
module seg_scan_lane (
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);
  // Full 0-F decode.
  always_comb begin
    seg_n = 7'h7F;
    case (nib)
      4'h0: seg_n = 7'b1000000;
      4'h1: seg_n = 7'b1111001;
      4'h2: seg_n = 7'b0100100;
      4'h3: seg_n = 7'b0110000;
      4'h4: seg_n = 7'b0011001;
      4'h5: seg_n = 7'b0010010;
      4'h6: seg_n = 7'b0000010;
      4'h7: seg_n = 7'b1111000;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0010000;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b0000011;
      4'hC: seg_n = 7'b1000110;
      4'hD: seg_n = 7'b0100001;
      4'hE: seg_n = 7'b0000110;
      default: seg_n = 7'b0001110;
    endcase
  end
endmodule

module seg_scan_mux #(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 65536,
  parameter int DUTY_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  input  logic [DUTY_BITS-1:0]  brightness,
  input  logic                  enable,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic                  frame_done
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [DUTY_BITS-1:0]      pwm_q, pwm_d;
  logic                      fd_q, fd_d;

  logic [DIGITS-1:0][3:0]    pend_data_q, pend_data_d;
  logic [DIGITS-1:0]         pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]         pend_blank_q, pend_blank_d;
  logic                      pend_vld_q, pend_vld_d;
  logic [DIGITS-1:0][3:0]    act_data_q, act_data_d;
  logic [DIGITS-1:0]         act_dp_q, act_dp_d;
  logic [DIGITS-1:0]         act_blank_q, act_blank_d;

  logic [6:0]                seg_q, seg_d;
  logic [DIGITS-1:0]         an_q, an_d;
  logic                      dp_q, dp_d;

  logic                      tick, wrap, lit, on;
  logic [DIGITS-1:0][6:0]    lane_seg;
  logic [6:0]                sel_seg;
  logic                      sel_dp, sel_blank;

  assign tick = enable && (cnt_q == CW'(TICK_DIV - 1));
  assign wrap = tick && (idx_q == IW'(DIGITS - 1));

  // One decoder per digit; the scan index picks which one reaches the pins.
  for (genvar g = 0; g < DIGITS; g++) begin : g_lane
    seg_scan_lane u_lane (.nib(act_data_q[g]), .seg_n(lane_seg[g]));
  end

  // Prescaler, digit index, free-running PWM and frame pulse.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (enable) cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (tick)   idx_d = wrap ? '0 : idx_q + 1'b1;
    pwm_d = pwm_q + 1'b1;
    fd_d  = wrap;
  end

  // Double buffer: pending is promoted only at a frame boundary, or at once
  // when scanning is stopped. Promotion reads the old pending contents, so a
  // load on the same cycle stays pending for the next boundary.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_vld_d   = pend_vld_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    if (pend_vld_q && (wrap || !enable)) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
      pend_vld_d  = 1'b0;
    end
    if (load) begin
      pend_data_d  = data;
      pend_dp_d    = dp_in;
      pend_blank_d = blank;
      pend_vld_d   = 1'b1;
    end
  end

  // Select the current digit and build the next pin state.
  always_comb begin
    sel_seg   = 7'h7F;
    sel_dp    = 1'b0;
    sel_blank = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_seg   = lane_seg[i];
        sel_dp    = act_dp_q[i];
        sel_blank = act_blank_q[i];
      end
    end
    // Full-scale brightness means always on, not "pwm < max".
    lit  = (brightness == {DUTY_BITS{1'b1}}) || (pwm_q < brightness);
    on   = enable && lit && !sel_blank;
    seg_d = on ? sel_seg : 7'h7F;
    dp_d  = on ? ~sel_dp : 1'b1;
    for (int i = 0; i < DIGITS; i++) an_d[i] = ~(on && (idx_q == IW'(i)));
  end

  // State and registered outputs; reset blanks the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      fd_q         <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_vld_q   <= 1'b0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      seg_q        <= 7'h7F;
      an_q         <= '1;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      fd_q         <= fd_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_vld_q   <= pend_vld_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;
endmodule
